// File: rtl/uart_cmd_rx.sv
// Purpose: 8N1 UART receiver that packs bytes little-endian into DATA_WIDTH-bit command words.
// Latency: word_out/word_valid update on the edge of the final stop-bit sample; 2-cycle synchronizer delay on uart_rxd.
// Backpressure: valid/ready holding register; a word completing while the register is full is dropped and sets sticky overrun.
module uart_cmd_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_WIDTH   = 32,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  uart_rxd,
    output logic [DATA_WIDTH-1:0] word_out,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam int NBYTES   = DATA_WIDTH / 8;
    localparam int BIW      = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW       = $clog2(TO_LIMIT + 1);

    localparam logic [CW-1:0]  HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [BIW-1:0] LAST_BYTE = BIW'(NBYTES - 1);
    localparam logic [TW-1:0]  TO_MAX    = TW'(TO_LIMIT);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    logic [1:0]            sync_q;
    logic                  rxd_s;
    state_t                state;
    logic [CW-1:0]         bit_cnt;
    logic [2:0]            bit_idx;
    logic [7:0]            shift_q;
    logic [BIW-1:0]        byte_idx;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0] acc_next;
    logic [TW-1:0]         idle_cnt;
    logic                  cnt_done;
    logic                  byte_ok;
    logic                  word_done;
    logic                  accept;

    assign rxd_s     = sync_q[1];
    assign cnt_done  = (bit_cnt == '0);
    assign byte_ok   = (state == STOP) && cnt_done && rxd_s;
    assign word_done = byte_ok && (byte_idx == LAST_BYTE);
    assign accept    = word_valid && word_ready;

    // Merge the received byte into its little-endian lane of the partial word.
    always_comb begin
        acc_next = acc_q;
        for (int i = 0; i < NBYTES; i++) begin
            if (byte_idx == BIW'(i)) begin
                acc_next[i*8 +: 8] = shift_q;
            end
        end
    end

    // Two-flop synchronizer; resets to the idle-high line level so no false start follows reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], uart_rxd};
        end
    end

    // Bit-level receive FSM, byte packing and inter-byte timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_q   <= '0;
            byte_idx  <= '0;
            acc_q     <= '0;
            idle_cnt  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (!cnt_done) begin
                bit_cnt <= bit_cnt - 1'b1;
            end
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state    <= START;
                        bit_cnt  <= HALF_LOAD;
                        idle_cnt <= '0;
                    end else if (byte_idx != '0) begin
                        // A stalled partial word is abandoned after a long idle gap.
                        if (idle_cnt == TO_MAX) begin
                            byte_idx <= '0;
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                START: begin
                    if (cnt_done) begin
                        if (rxd_s) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= FULL_LOAD;
                            bit_idx <= '0;
                        end
                    end
                end
                DATA: begin
                    if (cnt_done) begin
                        shift_q <= {rxd_s, shift_q[7:1]};
                        bit_cnt <= FULL_LOAD;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (cnt_done) begin
                        if (rxd_s) begin
                            state    <= IDLE;
                            acc_q    <= acc_next;
                            byte_idx <= word_done ? '0 : byte_idx + 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            byte_idx  <= '0;
                            state     <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rxd_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output holding register: a completing word loads if the slot is free or being drained this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (word_done) begin
            if (!word_valid || word_ready) begin
                word_out   <= acc_next;
                word_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (accept) begin
            word_valid <= 1'b0;
        end
    end

endmodule

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434: clk cycles per UART bit (50 MHz / 115200 baud); legal range 4 or more.
REQ-002 Parameter DATA_WIDTH, default 32: assembled command word width; a multiple of 8.
REQ-003 Parameter TIMEOUT_BITS, default 20: idle bit-periods between bytes before a partial word is discarded.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset; asserting low clears all state immediately.
REQ-006 Port uart_rxd, input, 1: asynchronous serial line, 8N1 format, idle high.
REQ-007 Port word_out, output, DATA_WIDTH: assembled command word.
REQ-008 Port word_valid, output, 1: word_out holds an unconsumed word.
REQ-009 Port word_ready, input, 1: consumer accepts word_out when word_valid and word_ready are both high on a rising edge.
REQ-010 Port frame_err, output, 1: one-cycle pulse when the stop bit samples low.
REQ-011 Port overrun, output, 1: sticky flag; a word was dropped because the holding register was full.

Function
REQ-012 uart_rxd shall pass through a 2-flop synchronizer; all logic uses only the synchronized value rxd_s.
REQ-013 The bit FSM shall have exactly five states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: when rxd_s==0, go to START and load the bit counter with CLKS_PER_BIT/2-1 (integer division).
REQ-015 START: at counter expiry (mid start bit), if rxd_s==1 this is a false start and the FSM returns to IDLE; otherwise go to DATA with the counter loaded to CLKS_PER_BIT-1.
REQ-016 DATA: sample rxd_s at each counter expiry, LSB first, and reload the counter; after 8 samples go to STOP.
REQ-017 STOP: at counter expiry, rxd_s==1 completes a byte and returns to IDLE; rxd_s==0 pulses frame_err, discards the byte and the partial word, and goes to WAIT_HIGH.
REQ-018 WAIT_HIGH: remain until rxd_s==1, then go to IDLE.
REQ-019 Completed bytes shall be packed little-endian: first byte into word bits [7:0]; a byte index 0..DATA_WIDTH/8-1 wraps to 0 when the word completes.
REQ-020 A completed word shall load word_out and set word_valid on the clock edge after the stop-bit sample cycle (latency 1 cycle).
REQ-021 word_out shall remain stable while word_valid is high and not accepted.
REQ-022 word_valid shall clear on the acceptance edge unless a new word completes on that same edge; in that case the new word loads and word_valid stays high.
REQ-023 If a word completes while word_valid is high and word_ready is low, the new word is dropped, overrun sets, and word_out is unchanged.
REQ-024 overrun clears only on reset.
REQ-025 Timeout: while the byte index is nonzero and the FSM is in IDLE, count idle cycles; at TIMEOUT_BITS*CLKS_PER_BIT cycles, reset the byte index to 0 and discard the partial bytes; the counter clears on each START entry.
REQ-026 The counter width shall be $clog2(TIMEOUT_BITS*CLKS_PER_BIT+1) bits; no counter shall wrap silently.

Reset
REQ-027 While reset is low: FSM=IDLE, synchronizer flops=1, byte index=0, all counters=0, word_out=0, word_valid=0, frame_err=0, overrun=0.
REQ-028 Reset asserted mid-frame shall abort the frame; after release, the first valid start bit begins a new word at byte index 0.

Verification (CLKS_PER_BIT=4, DATA_WIDTH=32, TIMEOUT_BITS=20)
REQ-029 Send bytes 0xEF,0xBE,0xAD,0xDE with word_ready=1 -> one word_valid pulse with word_out=0xDEADBEEF, 1 cycle after the 4th stop sample.
REQ-030 Send 2 words with word_ready=0 -> word_out=first word, overrun=1, word_valid stays 1; raise word_ready -> word_valid=0 next cycle.
REQ-031 Send byte 0x55 with stop bit 0 -> frame_err pulses 1 cycle, no word; hold line low 3 bit-times, then send 4 good bytes -> word assembles from byte 0.
REQ-032 Glitch rxd low for 1 cycle -> START then IDLE, no byte captured, no frame_err.
REQ-033 Send 2 bytes, idle 100 cycles, send 4 bytes 0x01..0x04 -> word_out=0x04030201.
REQ-034 Pull reset low during the DATA state of byte 3 -> all outputs 0; after release, 4 fresh bytes produce the correct word.
